// File: rtl/stoper_ctrl_if.sv
// Stopwatch controller bus: raw buttons and live counter value in,
// counter control and display selection out.
// The master side is the environment (buttons and counter); the slave side
// is the stoper_ctrl controller.
interface stoper_ctrl_if;
  logic        i_btn_ss;
  logic        i_btn_lc;
  logic [23:0] i_bcd_time;
  logic        o_cnt_en;
  logic        o_cnt_clr;
  logic [23:0] o_disp_bcd;
  logic        o_lap_active;
  logic [1:0]  o_state;

  modport master (
    output i_btn_ss,
    output i_btn_lc,
    output i_bcd_time,
    input  o_cnt_en,
    input  o_cnt_clr,
    input  o_disp_bcd,
    input  o_lap_active,
    input  o_state
  );

  modport slave (
    input  i_btn_ss,
    input  i_btn_lc,
    input  i_bcd_time,
    output o_cnt_en,
    output o_cnt_clr,
    output o_disp_bcd,
    output o_lap_active,
    output o_state
  );
endinterface

// File: rtl/stoper_ctrl.sv
// stoper_ctrl: start/stop/lap/clear controller for a 6-digit BCD stopwatch.
// - Two raw buttons are synchronized (2 flops) and debounced; a press event
//   is a one-cycle pulse on the debounced rising edge.
// - A 4-state FSM drives count enable, a one-cycle synchronous clear and the
//   display mux (live time or frozen lap time). All outputs are registered.
// - Optional build macro STOPER_CTRL_AUTOSTOP_EN: halts the count at 9:59.999
//   instead of letting the counter wrap. Without it the wrap is ignored.
module stoper_ctrl #(
  parameter int DEBOUNCE_CYCLES = 20
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  stoper_ctrl_if.slave bus
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_LIMIT = DB_W'(DEBOUNCE_CYCLES);
  localparam logic [DB_W-1:0] DB_ONE   = DB_W'(1);
  localparam logic [DB_W-1:0] DB_ZERO  = DB_W'(0);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_LAP  = 2'b10,
    ST_STOP = 2'b11
  } state_t;

  // Button index 0 is start/stop, index 1 is lap/clear.
  logic [1:0]      raw_s;
  logic [1:0]      meta_r;
  logic [1:0]      sync_r;
  logic [1:0]      db_r;
  logic [1:0]      db_d_r;
  logic [DB_W-1:0] db_cnt_r [2];
  logic [1:0]      ev_s;
  logic            ev_ss_s;
  logic            ev_lc_s;

  state_t          state_r;
  state_t          state_nxt_s;
  logic [23:0]     lap_r;
  logic [23:0]     lap_nxt_s;
  logic            clr_nxt_s;
  logic            autostop_s;

  logic            cnt_en_r;
  logic            cnt_clr_r;
  logic [23:0]     disp_bcd_r;
  logic            lap_active_r;

  assign raw_s = {bus.i_btn_lc, bus.i_btn_ss};

  // Two-flop synchronizers bring the asynchronous buttons into the clock domain.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      meta_r <= 2'b00;
      sync_r <= 2'b00;
    end else begin
      meta_r <= raw_s;
      sync_r <= meta_r;
    end
  end

  // Debounce: the level flips only once the synced input has differed from it
  // for DEBOUNCE_CYCLES consecutive cycles; any agreement restarts the count.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      db_r        <= 2'b00;
      db_d_r      <= 2'b00;
      db_cnt_r[0] <= DB_ZERO;
      db_cnt_r[1] <= DB_ZERO;
    end else begin
      db_d_r <= db_r;
      for (int i = 0; i < 2; i++) begin
        if (sync_r[i] == db_r[i]) begin
          db_cnt_r[i] <= DB_ZERO;
        end else if (db_cnt_r[i] == DB_LIMIT) begin
          db_r[i]     <= sync_r[i];
          db_cnt_r[i] <= DB_ZERO;
        end else begin
          db_cnt_r[i] <= db_cnt_r[i] + DB_ONE;
        end
      end
    end
  end

  // Press events fire on debounced rising edges only; start/stop has priority,
  // so a lap/clear press in the same cycle is dropped entirely.
  assign ev_s    = db_r & ~db_d_r;
  assign ev_ss_s = ev_s[0];
  assign ev_lc_s = ev_s[1] & ~ev_s[0];

`ifdef STOPER_CTRL_AUTOSTOP_EN
  // One count before 9:59.999 the next enabled tick reaches the last value,
  // so dropping the enable here freezes the counter at 24'h959999.
  assign autostop_s = ((state_r == ST_RUN) || (state_r == ST_LAP)) &&
                      cnt_en_r && (bus.i_bcd_time == 24'h959998);
`else
  assign autostop_s = 1'b0;
`endif

  // Next-state logic, lap capture and clear request.
  always_comb begin
    state_nxt_s = state_r;
    lap_nxt_s   = lap_r;
    clr_nxt_s   = 1'b0;
    if (autostop_s) begin
      state_nxt_s = ST_STOP;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (ev_ss_s) begin
            state_nxt_s = ST_RUN;
          end else if (ev_lc_s) begin
            state_nxt_s = ST_IDLE;
            clr_nxt_s   = 1'b1;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end
        ST_RUN: begin
          if (ev_ss_s) begin
            state_nxt_s = ST_STOP;
          end else if (ev_lc_s) begin
            state_nxt_s = ST_LAP;
            lap_nxt_s   = bus.i_bcd_time;
          end else begin
            state_nxt_s = ST_RUN;
          end
        end
        ST_LAP: begin
          if (ev_ss_s) begin
            state_nxt_s = ST_STOP;
          end else if (ev_lc_s) begin
            state_nxt_s = ST_RUN;
          end else begin
            state_nxt_s = ST_LAP;
          end
        end
        ST_STOP: begin
          if (ev_ss_s) begin
            state_nxt_s = ST_RUN;
          end else if (ev_lc_s) begin
            state_nxt_s = ST_IDLE;
            clr_nxt_s   = 1'b1;
          end else begin
            state_nxt_s = ST_STOP;
          end
        end
        default: begin
          state_nxt_s = ST_IDLE;
        end
      endcase
    end
  end

  // State, lap register and all outputs are registered from the next state so
  // every output changes in the same cycle the new state becomes visible.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r      <= ST_IDLE;
      lap_r        <= 24'h000000;
      cnt_en_r     <= 1'b0;
      cnt_clr_r    <= 1'b0;
      disp_bcd_r   <= 24'h000000;
      lap_active_r <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      lap_r        <= lap_nxt_s;
      cnt_en_r     <= (state_nxt_s == ST_RUN) || (state_nxt_s == ST_LAP);
      cnt_clr_r    <= clr_nxt_s;
      lap_active_r <= (state_nxt_s == ST_LAP);
      disp_bcd_r   <= (state_nxt_s == ST_LAP) ? lap_nxt_s : bus.i_bcd_time;
    end
  end

  assign bus.o_state      = state_r;
  assign bus.o_cnt_en     = cnt_en_r;
  assign bus.o_cnt_clr    = cnt_clr_r;
  assign bus.o_disp_bcd   = disp_bcd_r;
  assign bus.o_lap_active = lap_active_r;

endmodule

// File: tb/tb_stoper_ctrl.sv
// Self-checking bench for stoper_ctrl. Expected output snapshots are pushed to
// a queue as stimulus is applied and popped when the DUT outputs are sampled.
module tb_stoper_ctrl;

  localparam int DB = 20;
  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_RUN  = 2'b01;
  localparam logic [1:0] S_LAP  = 2'b10;
  localparam logic [1:0] S_STOP = 2'b11;

  typedef struct packed {
    logic [1:0]  st;
    logic        en;
    logic        clr;
    logic        lap;
    logic [23:0] disp;
  } obs_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   checks   = 0;
  int   failures = 0;
  obs_t exp_q[$];
  obs_t got;
  obs_t want;

  stoper_ctrl_if bus();

  stoper_ctrl #(.DEBOUNCE_CYCLES(DB)) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  function automatic obs_t mk(input logic [1:0] st, input logic en, input logic clr,
                              input logic lap, input logic [23:0] disp);
    obs_t o;
    o.st = st; o.en = en; o.clr = clr; o.lap = lap; o.disp = disp;
    return o;
  endfunction

  function automatic obs_t sample();
    return mk(bus.o_state, bus.o_cnt_en, bus.o_cnt_clr, bus.o_lap_active, bus.o_disp_bcd);
  endfunction

  // Raise the given buttons and return 1 ns after the edge where outputs react.
  task automatic press(input logic ss, input logic lc);
    @(posedge clk); #1;
    bus.i_btn_ss = ss;
    bus.i_btn_lc = lc;
    repeat (DB + 4) @(posedge clk);
    #1;
  endtask

  task automatic release_btns();
    bus.i_btn_ss = 1'b0;
    bus.i_btn_lc = 1'b0;
    repeat (DB + 6) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.i_btn_ss = 1'b0; bus.i_btn_lc = 1'b0; bus.i_bcd_time = 24'h123456;
    #2 rst_n = 1'b0;
    #1;
    exp_q.push_back(mk(S_IDLE, 1'b0, 1'b0, 1'b0, 24'h000000));
    got = sample(); want = exp_q.pop_front(); checks++;
    if (got !== want) begin failures++; $display("FAIL reset got=%h want=%h", got, want); end
    repeat (3) @(posedge clk);
    #1 bus.i_bcd_time = 24'h000000;
    rst_n = 1'b1;
  endtask

  task automatic test_bounce();
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      bus.i_btn_ss = (k < 5) || (k >= 8 && k < 13);
      exp_q.push_back(mk(S_IDLE, 1'b0, 1'b0, 1'b0, 24'h000000));
      got = sample(); want = exp_q.pop_front(); checks++;
      if (got !== want) begin failures++; $display("FAIL bounce k=%0d got=%h want=%h", k, got, want); end
    end
    release_btns();
  endtask

  task automatic test_start_latency();
    @(posedge clk); #1 bus.i_btn_ss = 1'b1;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk); #1;
      exp_q.push_back(mk((k >= 23) ? S_RUN : S_IDLE, k >= 23, 1'b0, 1'b0, 24'h000000));
      got = sample(); want = exp_q.pop_front(); checks++;
      if (got !== want) begin failures++; $display("FAIL start k=%0d got=%h want=%h", k, got, want); end
    end
    release_btns();
  endtask

  task automatic test_lap();
    bus.i_bcd_time = 24'h001234;
    exp_q.push_back(mk(S_LAP, 1'b1, 1'b0, 1'b1, 24'h001234));
    press(1'b0, 1'b1);
    got = sample(); want = exp_q.pop_front(); checks++;
    if (got !== want) begin failures++; $display("FAIL lap_enter got=%h want=%h", got, want); end
    bus.i_bcd_time = 24'h001240;
    exp_q.push_back(mk(S_LAP, 1'b1, 1'b0, 1'b1, 24'h001234));
    @(posedge clk); #1;
    got = sample(); want = exp_q.pop_front(); checks++;
    if (got !== want) begin failures++; $display("FAIL lap_hold got=%h want=%h", got, want); end
    release_btns();
    exp_q.push_back(mk(S_LAP, 1'b1, 1'b0, 1'b1, 24'h001234));
    got = sample(); want = exp_q.pop_front(); checks++;
    if (got !== want) begin failures++; $display("FAIL lap_hold_rel got=%h want=%h", got, want); end
    bus.i_bcd_time = 24'h001300;
    exp_q.push_back(mk(S_RUN, 1'b1, 1'b0, 1'b0, 24'h001300));
    press(1'b0, 1'b1);
    got = sample(); want = exp_q.pop_front(); checks++;
    if (got !== want) begin failures++; $display("FAIL lap_exit got=%h want=%h", got, want); end
    bus.i_bcd_time = 24'h001301;
    #3;
    exp_q.push_back(mk(S_RUN, 1'b1, 1'b0, 1'b0, 24'h001300));
    got = sample(); want = exp_q.pop_front(); checks++;
    if (got !== want) begin failures++; $display("FAIL live_lag got=%h want=%h", got, want); end
    exp_q.push_back(mk(S_RUN, 1'b1, 1'b0, 1'b0, 24'h001301));
    @(posedge clk); #1;
    got = sample(); want = exp_q.pop_front(); checks++;
    if (got !== want) begin failures++; $display("FAIL live_track got=%h want=%h", got, want); end
    release_btns();
  endtask

  task automatic test_stop_clear();
    exp_q.push_back(mk(S_STOP, 1'b0, 1'b0, 1'b0, 24'h001301));
    press(1'b1, 1'b0);
    got = sample(); want = exp_q.pop_front(); checks++;
    if (got !== want) begin failures++; $display("FAIL stop got=%h want=%h", got, want); end
    release_btns();
    bus.i_bcd_time = 24'h000777;
    for (int r = 0; r < 2; r++) begin
      exp_q.push_back(mk(S_IDLE, 1'b0, 1'b1, 1'b0, 24'h000777));
      exp_q.push_back(mk(S_IDLE, 1'b0, 1'b0, 1'b0, 24'h000777));
      press(1'b0, 1'b1);
      got = sample(); want = exp_q.pop_front(); checks++;
      if (got !== want) begin failures++; $display("FAIL clear_pulse r=%0d got=%h want=%h", r, got, want); end
      @(posedge clk); #1;
      got = sample(); want = exp_q.pop_front(); checks++;
      if (got !== want) begin failures++; $display("FAIL clear_end r=%0d got=%h want=%h", r, got, want); end
      release_btns();
    end
  endtask

  task automatic test_simultaneous();
    bus.i_bcd_time = 24'h000100;
    exp_q.push_back(mk(S_RUN, 1'b1, 1'b0, 1'b0, 24'h000100));
    press(1'b1, 1'b0);
    got = sample(); want = exp_q.pop_front(); checks++;
    if (got !== want) begin failures++; $display("FAIL sim_run got=%h want=%h", got, want); end
    release_btns();
    bus.i_bcd_time = 24'h000200;
    exp_q.push_back(mk(S_STOP, 1'b0, 1'b0, 1'b0, 24'h000200));
    press(1'b1, 1'b1);
    got = sample(); want = exp_q.pop_front(); checks++;
    if (got !== want) begin failures++; $display("FAIL sim_both got=%h want=%h", got, want); end
    release_btns();
    exp_q.push_back(mk(S_RUN, 1'b1, 1'b0, 1'b0, 24'h000200));
    press(1'b1, 1'b0);
    got = sample(); want = exp_q.pop_front(); checks++;
    if (got !== want) begin failures++; $display("FAIL resume got=%h want=%h", got, want); end
    release_btns();
  endtask

  task automatic test_back_to_back();
    bus.i_bcd_time = 24'h000500;
    exp_q.push_back(mk(S_LAP, 1'b1, 1'b0, 1'b1, 24'h000500));
    press(1'b0, 1'b1);
    got = sample(); want = exp_q.pop_front(); checks++;
    if (got !== want) begin failures++; $display("FAIL b2b_lap got=%h want=%h", got, want); end
    release_btns();
    bus.i_bcd_time = 24'h000600;
    exp_q.push_back(mk(S_STOP, 1'b0, 1'b0, 1'b0, 24'h000600));
    press(1'b1, 1'b0);
    got = sample(); want = exp_q.pop_front(); checks++;
    if (got !== want) begin failures++; $display("FAIL lap_to_stop got=%h want=%h", got, want); end
    release_btns();
    exp_q.push_back(mk(S_RUN, 1'b1, 1'b0, 1'b0, 24'h000600));
    press(1'b1, 1'b0);
    got = sample(); want = exp_q.pop_front(); checks++;
    if (got !== want) begin failures++; $display("FAIL b2b_resume got=%h want=%h", got, want); end
    release_btns();
  endtask

  task automatic test_autostop();
    @(posedge clk); #1 bus.i_bcd_time = 24'h959998;
`ifdef STOPER_CTRL_AUTOSTOP_EN
    exp_q.push_back(mk(S_STOP, 1'b0, 1'b0, 1'b0, 24'h959998));
    exp_q.push_back(mk(S_STOP, 1'b0, 1'b0, 1'b0, 24'h959999));
`else
    exp_q.push_back(mk(S_RUN, 1'b1, 1'b0, 1'b0, 24'h959998));
    exp_q.push_back(mk(S_RUN, 1'b1, 1'b0, 1'b0, 24'h959999));
`endif
    @(posedge clk); #1;
    got = sample(); want = exp_q.pop_front(); checks++;
    if (got !== want) begin failures++; $display("FAIL autostop got=%h want=%h", got, want); end
    bus.i_bcd_time = 24'h959999;
    @(posedge clk); #1;
    got = sample(); want = exp_q.pop_front(); checks++;
    if (got !== want) begin failures++; $display("FAIL autostop_hold got=%h want=%h", got, want); end
`ifdef STOPER_CTRL_AUTOSTOP_EN
    exp_q.push_back(mk(S_RUN, 1'b1, 1'b0, 1'b0, 24'h959999));
    press(1'b1, 1'b0);
    got = sample(); want = exp_q.pop_front(); checks++;
    if (got !== want) begin failures++; $display("FAIL autostop_resume got=%h want=%h", got, want); end
    release_btns();
`endif
  endtask

  task automatic test_async_reset();
    exp_q.push_back(mk(S_RUN, 1'b1, 1'b0, 1'b0, 24'h959999));
    got = sample(); want = exp_q.pop_front(); checks++;
    if (got !== want) begin failures++; $display("FAIL pre_reset got=%h want=%h", got, want); end
    #2 rst_n = 1'b0;
    #1;
    exp_q.push_back(mk(S_IDLE, 1'b0, 1'b0, 1'b0, 24'h000000));
    got = sample(); want = exp_q.pop_front(); checks++;
    if (got !== want) begin failures++; $display("FAIL async_reset got=%h want=%h", got, want); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_bounce();
    test_start_latency();
    test_lap();
    test_stop_clear();
    test_simultaneous();
    test_back_to_back();
    test_autostop();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
